// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-entry sequencer for the calculator datapath.
// Collects decimal digits into operand A, latches an operator, collects
// operand B, then launches the arithmetic unit on "equal" through a
// start/done handshake and shows the captured result.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   key_en, in          key strobe and key code (0-9 digit, 10-13 op,
//                       14 clear, 15 backspace)
//   equal               evaluate strobe (wins over a simultaneous key)
//   alu_a, alu_b        operands to the arithmetic unit
//   alu_op              00 add, 01 sub, 10 mul, 11 div
//   alu_start           one-cycle launch pulse
//   alu_done            one-cycle completion pulse
//   alu_result, alu_err result and error, valid with alu_done
//   disp, err           display value and error flag
//   busy                high while waiting on the arithmetic unit
module calc_ctrl #(
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_DIGITS = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_en,
  input  logic [3:0]     in,
  input  logic           equal,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [1:0]     alu_op,
  output logic           alu_start,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result,
  input  logic           alu_err,
  output logic [2*W-1:0] disp,
  output logic           err,
  output logic           busy
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_RES} state_t;

  state_t        state;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [1:0]    op;
  logic [TW-1:0] timer;

  logic          key_live;
  logic          is_digit;
  logic          is_op;
  logic          is_clr;
  logic          is_bksp;
  logic [1:0]    key_op;
  logic [W+3:0]  num1_mac;
  logic [W+3:0]  num2_mac;
  logic [W-1:0]  num1_div;
  logic [W-1:0]  num2_div;
  logic          res_fits;
  logic [CW-1:0] max_cnt;

  always_comb begin
    // A key is dropped whenever equal is asserted in the same cycle.
    key_live = key_en && !equal;
    is_digit = key_live && (in <= 4'd9);
    is_op    = key_live && (in >= 4'd10) && (in <= 4'd13);
    is_clr   = key_live && (in == 4'd14);
    is_bksp  = key_live && (in == 4'd15);
    // Codes 10..13 map to op 0..3; the low two bits minus 2 do that mod 4.
    key_op   = in[1:0] - 2'd2;
    num1_mac = ({4'b0000, num1} * (W+4)'(10)) + (W+4)'(in);
    num2_mac = ({4'b0000, num2} * (W+4)'(10)) + (W+4)'(in);
    num1_div = num1 / W'(10);
    num2_div = num2 / W'(10);
    res_fits = (disp[2*W-1:W] == '0);
    max_cnt  = CW'(MAX_DIGITS);
  end

  always_ff @(posedge clk) begin
    // Clear returns every register to its reset value, so it shares the
    // reset branch.
    if (!rst_n || is_clr) begin
      state     <= S_A;
      num1      <= '0;
      num2      <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      op        <= '0;
      timer     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      disp      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        S_A: begin
          if (is_digit) begin
            if (cnt_a < max_cnt) begin
              num1  <= num1_mac[W-1:0];
              cnt_a <= cnt_a + CW'(1);
              disp  <= (2*W)'(num1_mac[W-1:0]);
            end
          end else if (is_op) begin
            op    <= key_op;
            num2  <= '0;
            cnt_b <= '0;
            state <= S_B;
            disp  <= (2*W)'(num1);
          end else if (is_bksp) begin
            if (cnt_a != '0) begin
              num1  <= num1_div;
              cnt_a <= cnt_a - CW'(1);
              disp  <= (2*W)'(num1_div);
            end
          end
        end

        S_B: begin
          if (equal) begin
            if (cnt_b != '0) begin
              alu_a     <= num1;
              alu_b     <= num2;
              alu_op    <= op;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              timer     <= '0;
              state     <= S_EXEC;
            end
          end else if (is_digit) begin
            if (cnt_b < max_cnt) begin
              num2  <= num2_mac[W-1:0];
              cnt_b <= cnt_b + CW'(1);
              disp  <= (2*W)'(num2_mac[W-1:0]);
            end
          end else if (is_op) begin
            if (cnt_b == '0) op <= key_op;
          end else if (is_bksp) begin
            if (cnt_b != '0) begin
              num2  <= num2_div;
              cnt_b <= cnt_b - CW'(1);
              // Erasing the last B digit falls back to showing A.
              disp  <= (cnt_b == CW'(1)) ? (2*W)'(num1) : (2*W)'(num2_div);
            end else begin
              state <= S_A;
              disp  <= (2*W)'(num1);
            end
          end
        end

        S_EXEC: begin
          if (alu_done) begin
            disp  <= alu_result;
            err   <= alu_err;
            busy  <= 1'b0;
            state <= S_RES;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            disp  <= '0;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_RES;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_RES: begin
          if (is_digit) begin
            num1  <= W'(in);
            cnt_a <= CW'(1);
            err   <= 1'b0;
            state <= S_A;
            disp  <= (2*W)'(in);
          end else if (is_op) begin
            // Chain from the result only when it is valid and fits in W bits;
            // A is marked full so no digits can be appended to it.
            if (!err && res_fits) begin
              num1  <= disp[W-1:0];
              cnt_a <= max_cnt;
              op    <= key_op;
              num2  <= '0;
              cnt_b <= '0;
              state <= S_B;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  localparam int W    = 8;
  localparam int MAXD = 2;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_en = 1'b0;
  logic [3:0]  in = '0;
  logic        equal = 1'b0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_err = 1'b0;
  logic [15:0] disp;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  calc_ctrl #(.W(W), .MAX_DIGITS(MAXD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key_en(key_en), .in(in), .equal(equal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp(disp), .err(err), .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct { string name; int disp; int err; int busy; int start; } key_exp_t;
  typedef struct { int a; int b; int op; } start_exp_t;
  typedef struct { int disp; int err; int cycles; } res_exp_t;

  key_exp_t   q_key[$];
  start_exp_t q_start[$];
  res_exp_t   q_res[$];

  // Reference model: calculator state held as plain integers.
  typedef enum {M_A, M_B, M_EXEC, M_RES} mstate_t;
  mstate_t m_st = M_A;
  int m_num1 = 0, m_num2 = 0, m_cnta = 0, m_cntb = 0, m_op = 0;
  int m_disp = 0, m_err = 0;
  int ex_a = 0, ex_b = 0, ex_op = 0;

  function automatic void model_zero();
    if (m_st == M_EXEC) q_res.push_back('{0, 0, -1});
    m_st = M_A; m_num1 = 0; m_num2 = 0; m_cnta = 0; m_cntb = 0; m_op = 0;
    m_disp = 0; m_err = 0;
  endfunction

  function automatic void push_key(input string n, input int start);
    q_key.push_back('{n, m_disp, m_err, (m_st == M_EXEC) ? 1 : 0, start});
  endfunction

  function automatic void model_key(input int k, input string n);
    if (k == 14) model_zero();
    else begin
      case (m_st)
        M_A: begin
          if (k <= 9) begin
            if (m_cnta < MAXD) begin m_num1 = m_num1 * 10 + k; m_cnta++; end
            m_disp = m_num1;
          end else if (k <= 13) begin
            m_op = k - 10; m_num2 = 0; m_cntb = 0; m_st = M_B; m_disp = m_num1;
          end else begin
            if (m_cnta > 0) begin m_num1 = m_num1 / 10; m_cnta--; end
            m_disp = m_num1;
          end
        end
        M_B: begin
          if (k <= 9) begin
            if (m_cntb < MAXD) begin m_num2 = m_num2 * 10 + k; m_cntb++; end
            m_disp = m_num2;
          end else if (k <= 13) begin
            if (m_cntb == 0) m_op = k - 10;
          end else begin
            if (m_cntb > 0) begin
              m_num2 = m_num2 / 10; m_cntb--;
              m_disp = (m_cntb > 0) ? m_num2 : m_num1;
            end else begin
              m_st = M_A; m_disp = m_num1;
            end
          end
        end
        M_EXEC: ;
        M_RES: begin
          if (k <= 9) begin
            m_num1 = k; m_cnta = 1; m_err = 0; m_st = M_A; m_disp = k;
          end else if (k <= 13) begin
            if (m_err == 0 && m_disp < 256) begin
              m_num1 = m_disp; m_cnta = MAXD; m_op = k - 10;
              m_num2 = 0; m_cntb = 0; m_st = M_B;
            end
          end
        end
      endcase
    end
    push_key(n, 0);
  endfunction

  function automatic void model_equal(input string n);
    if (m_st == M_B && m_cntb > 0) begin
      q_start.push_back('{m_num1, m_num2, m_op});
      ex_a = m_num1; ex_b = m_num2; ex_op = m_op;
      m_st = M_EXEC;
      push_key(n, 1);
    end else push_key(n, 0);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input int k, input string n);
    key_en = 1'b1; in = 4'(k);
    model_key(k, n);
    tick();
    key_en = 1'b0;
  endtask

  task automatic press_eq(input string n);
    equal = 1'b1;
    model_equal(n);
    tick();
    equal = 1'b0;
  endtask

  task automatic press_both(input int k, input string n);
    key_en = 1'b1; in = 4'(k); equal = 1'b1;
    model_equal(n);
    tick();
    key_en = 1'b0; equal = 1'b0;
  endtask

  // Arithmetic-unit model: answers lat cycles after the launch.
  task automatic alu_respond(input int lat);
    int res;
    int e;
    e = 0;
    case (ex_op)
      0: res = ex_a + ex_b;
      1: res = (ex_a - ex_b) & 16'hFFFF;
      2: res = ex_a * ex_b;
      default: if (ex_b == 0) begin res = 0; e = 1; end else res = ex_a / ex_b;
    endcase
    repeat (lat) tick();
    alu_done = 1'b1; alu_result = 16'(res); alu_err = e[0];
    m_st = M_RES; m_disp = res; m_err = e;
    q_res.push_back('{res, e, lat + 1});
    tick();
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
  endtask

  task automatic timeout_wait();
    m_st = M_RES; m_disp = 0; m_err = 1;
    q_res.push_back('{0, 1, TO});
    repeat (TO + 4) tick();
  endtask

  task automatic check_zero(input string n);
    @(negedge clk);
    check({n, "/alu_a"}, alu_a, 0);
    check({n, "/alu_b"}, alu_b, 0);
    check({n, "/alu_op"}, alu_op, 0);
    check({n, "/alu_start"}, alu_start, 0);
    check({n, "/disp"}, disp, 0);
    check({n, "/err"}, err, 0);
    check({n, "/busy"}, busy, 0);
  endtask

  // Monitor: every accepted strobe has its effect visible one cycle later.
  initial begin : key_mon
    key_exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && (key_en || equal)) begin
        @(negedge clk);
        if (q_key.size() == 0) check("key_pending", 0, 1);
        else begin
          e = q_key.pop_front();
          check({e.name, "/disp"}, disp, e.disp);
          check({e.name, "/err"}, err, e.err);
          check({e.name, "/busy"}, busy, e.busy);
          check({e.name, "/alu_start"}, alu_start, e.start);
        end
      end
    end
  end

  // Monitor: launch operands and result capture.
  logic prev_start = 1'b0;
  logic prev_busy  = 1'b0;
  int   busy_cnt   = 0;

  always @(negedge clk) begin
    start_exp_t s;
    res_exp_t   r;
    if (alu_start === 1'b1) begin
      check("start_single", prev_start, 0);
      if (q_start.size() == 0) check("start_pending", 0, 1);
      else begin
        s = q_start.pop_front();
        check("launch/alu_a", alu_a, s.a);
        check("launch/alu_b", alu_b, s.b);
        check("launch/alu_op", alu_op, s.op);
      end
    end
    prev_start = (alu_start === 1'b1);
    if (busy === 1'b1) busy_cnt++;
    else begin
      if (prev_busy) begin
        if (q_res.size() == 0) check("result_pending", 0, 1);
        else begin
          r = q_res.pop_front();
          check("result/disp", disp, r.disp);
          check("result/err", err, r.err);
          if (r.cycles >= 0) check("result/busy_cycles", busy_cnt, r.cycles);
        end
      end
      busy_cnt = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int r;
    int k;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // 12 + 34 with a 3-cycle arithmetic unit
    press(1, "t1_1"); press(2, "t1_2"); press(10, "t1_add");
    press(3, "t1_3"); press(4, "t1_4"); press_eq("t1_eq");
    alu_respond(3);

    // digit limit and backspace down to empty
    press(14, "t2_clr");
    press(9, "t2_9a"); press(9, "t2_9b"); press(9, "t2_9c");
    press(15, "t2_bs1"); press(15, "t2_bs2"); press(15, "t2_bs3");
    press(3, "t2_3");

    // backspace out of B, then operator replacement with empty B
    press(14, "t3_clr"); press(5, "t3_5"); press(12, "t3_mul");
    press(15, "t3_bs"); press(11, "t3_sub"); press(2, "t3_2");
    press_eq("t3_eq"); alu_respond(2);
    press(14, "t3_clr2"); press(1, "t3_1"); press(10, "t3_add");
    press(13, "t3_div"); press(3, "t3_3"); press_eq("t3_eq2"); alu_respond(4);

    // divide by zero, operator ignored on error, digit recovers
    press(14, "t4_clr"); press(7, "t4_7"); press(13, "t4_div");
    press(0, "t4_0"); press_eq("t4_eq"); alu_respond(2);
    press(10, "t4_op_ignored"); press(4, "t4_4");

    // chaining from a result
    press(14, "t5_clr"); press(2, "t5_2"); press(10, "t5_add");
    press(3, "t5_3"); press_eq("t5_eq"); alu_respond(2);
    press(12, "t5_chain_mul"); press(4, "t5_4"); press_eq("t5_eq2"); alu_respond(5);

    // timeout, then clear aborting a wait and a stray late done
    press(14, "t6_clr"); press(6, "t6_6"); press(10, "t6_add");
    press(1, "t6_1"); press_eq("t6_eq"); timeout_wait();
    press(10, "t6_op_ignored");
    press(14, "t6_clr2"); press(6, "t6_6b"); press(10, "t6_addb");
    press(1, "t6_1b"); press_eq("t6_eqb");
    repeat (5) tick();
    press(14, "t6_abort");
    repeat (3) tick();
    alu_done = 1'b1; alu_result = 16'd123;
    tick();
    alu_done = 1'b0; alu_result = '0;
    @(negedge clk);
    check("t6_late_done/disp", disp, 0);
    check("t6_late_done/err", err, 0);
    tick();

    // equal and key together, then reset in the middle of a wait
    press(14, "t7_clr"); press(3, "t7_3"); press(10, "t7_add"); press(4, "t7_4");
    press_both(5, "t7_both"); alu_respond(2);
    press(14, "t7_clr2"); press(8, "t7_8"); press(11, "t7_sub"); press(2, "t7_2");
    press_eq("t7_eq"); repeat (3) tick();
    rst_n = 1'b0;
    model_zero();
    tick();
    check_zero("t7_reset_mid");
    rst_n = 1'b1;
    tick();

    // randomized key traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6 && m_st == M_B && m_cntb > 0) begin
        press_both(int'($urandom_range(0, 15)), "rnd_both");
      end else if (r < 22) begin
        press_eq("rnd_eq");
      end else begin
        k = int'($urandom_range(0, 15));
        if (k == 14 && $urandom_range(0, 4) != 0) k = int'($urandom_range(0, 9));
        press(k, "rnd_key");
      end
      if (m_st == M_EXEC) begin
        if ($urandom_range(0, 7) == 0) begin
          repeat ($urandom_range(1, 5)) tick();
          press(14, "rnd_abort");
        end else alu_respond(int'($urandom_range(1, 6)));
      end
    end

    repeat (3) tick();
    check("end/key_queue", q_key.size(), 0);
    check("end/start_queue", q_start.size(), 0);
    check("end/result_queue", q_res.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
